// File: rtl/readout_sequencer.sv
// readout_sequencer: runs one capture-and-readout cycle for the four-channel
// acquisition block. It pulses start_trigger, waits for a fresh data_ready,
// then walks the sample RAM from the pre-trigger start address, with
// wrap-around. The enabled channels' bytes are streamed, channel by channel,
// into the TX byte path over a valid/ready handshake.
// Optional build macro READOUT_HEADER_EN: a two-byte header is sent before the
// sample data. The header is 0xA5 followed by {4'h0, chan_mask}.
module readout_sequencer #(
  parameter int unsigned RAM_WIDTH   = 10,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cmd_read,
  input  logic                 cmd_abort,
  input  logic [3:0]           chan_mask,
  input  logic [RAM_WIDTH-1:0] nsmp,
  input  logic [RAM_WIDTH-1:0] triggerpoint,
  output logic                 start_trigger,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  input  logic [31:0]          ram_q,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW = RAM_WIDTH + 1;
  localparam int unsigned LW = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_READY,
`ifdef READOUT_HEADER_EN
    HDR,
`endif
    ADDR,
    RDWAIT,
    SEND,
    DONE
  } state_t;

  state_t state, state_d;

  logic [3:0]           rem_mask;
  logic [RAM_WIDTH-1:0] nsmp_q;
  logic [RAM_WIDTH-1:0] trig_q;
  logic [RAM_WIDTH-1:0] start_addr;
  logic [RAM_WIDTH-1:0] cur;
  logic [CW-1:0]        smp_cnt;
  logic [LW-1:0]        lat_cnt;
`ifdef READOUT_HEADER_EN
  logic [3:0]           mask_q;
  logic                 hdr_idx;
`endif

  logic [1:0] ch;
  logic [3:0] rem_next;
  logic       last_smp;
  logic       lat_done;
  logic       empty_job;

  function automatic logic [1:0] low_ch(input logic [3:0] m);
    logic [1:0] r;
    logic       found;
    r     = 2'd0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (m[i] && !found) begin
        r     = 2'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Channel selection and the end-of-channel / end-of-latency conditions.
  always_comb begin
    ch        = low_ch(rem_mask);
    rem_next  = rem_mask & ~(4'b0001 << ch);
    last_smp  = (smp_cnt + CW'(1)) == {1'b0, nsmp_q};
    lat_done  = lat_cnt == LW'(RAM_LATENCY - 1);
    empty_job = (rem_mask == '0) || (nsmp_q == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; abort overrides every transition, including a start in IDLE.
  always_comb begin
    state_d = state;
    if (cmd_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE:       if (cmd_read) state_d = ARM;
        ARM:        if (!data_ready) state_d = WAIT_READY;
`ifdef READOUT_HEADER_EN
        WAIT_READY: if (data_ready) state_d = HDR;
        HDR:        if (tx_ready && hdr_idx) state_d = empty_job ? DONE : ADDR;
`else
        WAIT_READY: if (data_ready) state_d = empty_job ? DONE : ADDR;
`endif
        ADDR:       state_d = RDWAIT;
        RDWAIT:     if (lat_done) state_d = SEND;
        SEND: begin
          if (tx_ready) state_d = (last_smp && (rem_next == '0)) ? DONE : ADDR;
        end
        DONE:       state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy      = state != IDLE;
    done      = state == DONE;
    rden      = state == ADDR;
    rdaddress = (state == ADDR) ? cur : '0;
`ifdef READOUT_HEADER_EN
    tx_valid  = (state == SEND) || (state == HDR);
`else
    tx_valid  = state == SEND;
`endif
  end

  // Datapath: command latching, address walk, sample counting and TX byte register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_trigger <= 1'b0;
      tx_data       <= '0;
      rem_mask      <= '0;
      nsmp_q        <= '0;
      trig_q        <= '0;
      start_addr    <= '0;
      cur           <= '0;
      smp_cnt       <= '0;
      lat_cnt       <= '0;
`ifdef READOUT_HEADER_EN
      mask_q        <= '0;
      hdr_idx       <= 1'b0;
`endif
    end else begin
      start_trigger <= 1'b0;
      if (cmd_abort) begin
        tx_data <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_read) begin
              rem_mask      <= chan_mask;
              nsmp_q        <= nsmp;
              trig_q        <= triggerpoint;
              start_trigger <= 1'b1;
`ifdef READOUT_HEADER_EN
              mask_q        <= chan_mask;
`endif
            end
          end
          WAIT_READY: begin
            if (data_ready) begin
              start_addr <= wraddress_triggerpoint - trig_q;
              cur        <= wraddress_triggerpoint - trig_q;
              smp_cnt    <= '0;
`ifdef READOUT_HEADER_EN
              tx_data    <= 8'hA5;
              hdr_idx    <= 1'b0;
`endif
            end
          end
`ifdef READOUT_HEADER_EN
          HDR: begin
            if (tx_ready && !hdr_idx) begin
              tx_data <= {4'h0, mask_q};
              hdr_idx <= 1'b1;
            end
          end
`endif
          ADDR: lat_cnt <= '0;
          RDWAIT: begin
            if (lat_done) tx_data <= ram_q[{ch, 3'b000} +: 8];
            else          lat_cnt <= lat_cnt + LW'(1);
          end
          SEND: begin
            if (tx_ready) begin
              // End of a channel rewinds to the shared start address for the next lane.
              if (last_smp) begin
                smp_cnt  <= '0;
                cur      <= start_addr;
                rem_mask <= rem_next;
              end else begin
                smp_cnt <= smp_cnt + CW'(1);
                cur     <= cur + RAM_WIDTH'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
